// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the register-read stage.
//   decoded_t   : decoded instruction fields handed from decode to execute
//   rrm_entry_t : one buffered slot (decoded instruction + exception tag)
//   REG_X0      : index of the hard-wired zero register, never a hazard
package pipeline_pkg;

  localparam int PKG_XLEN   = 32;
  localparam int PKG_REG_AW = 5;
  localparam int EXC_NUM_W  = 6;

  localparam logic [PKG_REG_AW-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [6:0]            opcode;
    logic [PKG_REG_AW-1:0] rd;
    logic [PKG_REG_AW-1:0] rs1;
    logic [PKG_REG_AW-1:0] rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [PKG_XLEN-1:0]   imm;
    logic [PKG_XLEN-1:0]   pc;
  } decoded_t;

  typedef struct packed {
    logic                 exc_valid;
    logic [EXC_NUM_W-1:0] exc_num;
    decoded_t             instr;
  } rrm_entry_t;

endpackage

// File: rtl/rrm_fifo.sv
// Generic circular buffer of DEPTH entries (any DEPTH >= 1).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (all storage cleared)
//   push, din    : write din at the tail (ignored when full and not popping)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the buffer; beats push and pop
//   dout         : head entry, combinational
//   count        : number of stored entries, 0..DEPTH
module rrm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the storage array is reset as well, so the head outputs read as
  // zero straight out of reset rather than X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/read_registers_multi.sv
// Register-read stage: buffers decoded instructions, reads rs1/rs2 for the
// head entry and issues it once no RAW hazard exists against NUM_HAZ
// in-flight writers (index 0 = youngest).
// Optional feature macro: RRM_BYPASS_EN -- forward a ready writer result
// instead of waiting for writeback.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   flush                         : drop all buffered entries
//   decode_instr/exc_num/exc_valid/valid -> decode_stall : decode handshake
//   read_rs1/read_rs2, rs1_val/rs2_val : register-file read (combinational)
//   haz_valid/haz_rd/haz_data_rdy/haz_data : in-flight writer state
//   instr_out, rs1_val_out, rs2_val_out, exc_num_out, exc_valid_out : head
//   valid                         : head issues this cycle; stall from execute
module read_registers_multi
  import pipeline_pkg::*;
#(
  parameter int XLEN      = PKG_XLEN,
  parameter int REG_AW    = PKG_REG_AW,
  parameter int BUF_DEPTH = 2,
  parameter int NUM_HAZ   = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  decoded_t                  decode_instr,
  input  logic [EXC_NUM_W-1:0]      decode_exc_num,
  input  logic                      decode_exc_valid,
  input  logic                      decode_valid,
  output logic                      decode_stall,
  output logic [REG_AW-1:0]         read_rs1,
  output logic [REG_AW-1:0]         read_rs2,
  input  logic [XLEN-1:0]           rs1_val,
  input  logic [XLEN-1:0]           rs2_val,
  input  logic [NUM_HAZ-1:0]        haz_valid,
  input  logic [NUM_HAZ*REG_AW-1:0] haz_rd,
  input  logic [NUM_HAZ-1:0]        haz_data_rdy,
  input  logic [NUM_HAZ*XLEN-1:0]   haz_data,
  output decoded_t                  instr_out,
  output logic [XLEN-1:0]           rs1_val_out,
  output logic [XLEN-1:0]           rs2_val_out,
  output logic [EXC_NUM_W-1:0]      exc_num_out,
  output logic                      exc_valid_out,
  output logic                      valid,
  input  logic                      stall
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  rrm_entry_t               push_entry;
  rrm_entry_t               head;
  logic [CNT_W-1:0]         count;
  logic                     empty;
  logic                     full;
  logic                     issue;
  logic                     push;
  logic [1:0][REG_AW-1:0]   src;      // [0] = rs1, [1] = rs2
  logic [1:0][NUM_HAZ-1:0]  match;
  logic [1:0]               blk;
  logic [1:0][XLEN-1:0]     src_val;

  assign push_entry = '{exc_valid: decode_exc_valid, exc_num: decode_exc_num,
                        instr: decode_instr};

  rrm_fifo #(
    .WIDTH ($bits(rrm_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (issue),
    .flush   (flush),
    .din     (push_entry),
    .dout    (head),
    .count   (count)
  );

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(BUF_DEPTH));

  assign src[0] = head.instr.rs1;
  assign src[1] = head.instr.rs2;

  // x0 reads as zero and can never be a true dependency.
  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar h = 0; h < NUM_HAZ; h++) begin : g_haz
      assign match[s][h] = haz_valid[h] && (src[s] != REG_X0) &&
                           (haz_rd[h*REG_AW +: REG_AW] == src[s]);
    end
  end

`ifdef RRM_BYPASS_EN
  // Scan from the oldest writer down so the youngest (lowest index) match
  // is the one left standing.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    blk     = '0;
    src_val = {rs2_val, rs1_val};
    for (int s = 0; s < 2; s++) begin
      for (int h = NUM_HAZ - 1; h >= 0; h--) begin
        if (match[s][h]) begin
          blk[s]     = ~haz_data_rdy[h];
          src_val[s] = haz_data[h*XLEN +: XLEN];
        end
      end
    end
  end
`else
  always_comb begin
    blk     = '0;
    src_val = {rs2_val, rs1_val};
    for (int s = 0; s < 2; s++) blk[s] = |match[s];
  end

  // Writer results are only consumed by the forwarding build.
  logic unused_bypass;
  assign unused_bypass = ^{haz_data_rdy, haz_data};
`endif

  // An excepting entry carries no real operands, so it never waits.
  assign issue = ~flush & ~stall & ~empty & (head.exc_valid | ~(|blk));
  assign decode_stall = ~flush & full & ~issue;
  assign push  = decode_valid & ~decode_stall & ~flush;

  assign valid         = issue;
  assign read_rs1      = src[0];
  assign read_rs2      = src[1];
  assign instr_out     = head.instr;
  assign exc_num_out   = head.exc_num;
  assign exc_valid_out = head.exc_valid;
  assign rs1_val_out   = src_val[0];
  assign rs2_val_out   = src_val[1];

endmodule

// File: tb/tb_read_registers_multi.sv
// Directed bench for read_registers_multi (forwarding disabled build).
// Expected head entries are queued when decode is driven and popped when the
// stage issues.
module tb_read_registers_multi;
  import pipeline_pkg::*;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int BUF_DEPTH = 2;
  localparam int NUM_HAZ   = 2;

  localparam logic [XLEN-1:0] RF1 = 32'h1111_1111;
  localparam logic [XLEN-1:0] RF2 = 32'h2222_2222;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      flush;
  decoded_t                  decode_instr;
  logic [EXC_NUM_W-1:0]      decode_exc_num;
  logic                      decode_exc_valid;
  logic                      decode_valid;
  logic                      decode_stall;
  logic [REG_AW-1:0]         read_rs1;
  logic [REG_AW-1:0]         read_rs2;
  logic [XLEN-1:0]           rs1_val;
  logic [XLEN-1:0]           rs2_val;
  logic [NUM_HAZ-1:0]        haz_valid;
  logic [NUM_HAZ*REG_AW-1:0] haz_rd;
  logic [NUM_HAZ-1:0]        haz_data_rdy;
  logic [NUM_HAZ*XLEN-1:0]   haz_data;
  decoded_t                  instr_out;
  logic [XLEN-1:0]           rs1_val_out;
  logic [XLEN-1:0]           rs2_val_out;
  logic [EXC_NUM_W-1:0]      exc_num_out;
  logic                      exc_valid_out;
  logic                      valid;
  logic                      stall;

  typedef struct {
    decoded_t             instr;
    logic                 ev;
    logic [EXC_NUM_W-1:0] en;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  read_registers_multi #(
    .XLEN(XLEN), .REG_AW(REG_AW), .BUF_DEPTH(BUF_DEPTH), .NUM_HAZ(NUM_HAZ)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush            (flush),
    .decode_instr     (decode_instr),
    .decode_exc_num   (decode_exc_num),
    .decode_exc_valid (decode_exc_valid),
    .decode_valid     (decode_valid),
    .decode_stall     (decode_stall),
    .read_rs1         (read_rs1),
    .read_rs2         (read_rs2),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .haz_valid        (haz_valid),
    .haz_rd           (haz_rd),
    .haz_data_rdy     (haz_data_rdy),
    .haz_data         (haz_data),
    .instr_out        (instr_out),
    .rs1_val_out      (rs1_val_out),
    .rs2_val_out      (rs2_val_out),
    .exc_num_out      (exc_num_out),
    .exc_valid_out    (exc_valid_out),
    .valid            (valid),
    .stall            (stall)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic decoded_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm);
    decoded_t d;
    d        = '0;
    d.opcode = 7'h13;
    d.rd     = rd;
    d.rs1    = rs1;
    d.rs2    = rs2;
    d.funct3 = rd[2:0];
    d.funct7 = {2'b0, rs1};
    d.imm    = imm;
    d.pc     = 32'h1000 + (imm << 2);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drive an entry at decode; queue it as expected when acceptance is expected.
  task automatic offer(input decoded_t d, input logic ev, input logic [5:0] en,
                       input bit expect_accept);
    sb_t e;
    decode_instr     = d;
    decode_exc_valid = ev;
    decode_exc_num   = en;
    decode_valid     = 1'b1;
    if (expect_accept) begin
      e.instr = d;
      e.ev    = ev;
      e.en    = en;
      sb.push_back(e);
    end
  endtask

  task automatic idle_decode();
    decode_valid     = 1'b0;
    decode_instr     = '0;
    decode_exc_valid = 1'b0;
    decode_exc_num   = '0;
  endtask

  task automatic pop_check(input string tag);
    sb_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 128'(sb.size()), 128'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_instr"}, instr_out, e.instr);
      check({tag, "_exc_v"}, exc_valid_out, e.ev);
      check({tag, "_exc_n"}, exc_num_out, e.en);
      if (!e.ev) begin
        check({tag, "_rs1v"}, rs1_val_out, RF1);
        check({tag, "_rs2v"}, rs2_val_out, RF2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    flush        = 1'b0;
    stall        = 1'b0;
    rs1_val      = RF1;
    rs2_val      = RF2;
    haz_valid    = '0;
    haz_rd       = '0;
    haz_data_rdy = '0;
    haz_data     = '0;
    idle_decode();

    // Reset state
    #12;
    check("rst_valid", valid, 1'b0);
    check("rst_dstall", decode_stall, 1'b0);
    check("rst_rs1", read_rs1, '0);
    check("rst_rs2", read_rs2, '0);
    check("rst_instr", instr_out, '0);
    check("rst_excv", exc_valid_out, 1'b0);
    check("rst_excn", exc_num_out, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 1: simple push, issues one cycle later with regfile operands
    offer(mk(5'd3, 5'd1, 5'd0, 32'd5), 1'b0, 6'd0, 1'b1);
    settle();
    check("t1_dstall", decode_stall, 1'b0);
    check("t1_empty_valid", valid, 1'b0);
    tick();
    idle_decode();
    settle();
    check("t1_valid", valid, 1'b1);
    check("t1_rs1", read_rs1, 5'd1);
    pop_check("t1");
    tick();
    settle();
    check("t1_drained", valid, 1'b0);

    // 2: rs1 hazard on writer 1 for three cycles; ready data must not help
    offer(mk(5'd6, 5'd5, 5'd0, 32'd7), 1'b0, 6'd0, 1'b1);
    tick();
    idle_decode();
    haz_valid    = 2'b10;
    haz_rd       = {5'd5, 5'd0};
    haz_data_rdy = 2'b10;
    haz_data     = {32'h0000_DEAD, 32'h0};
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("t2_blocked%0d", k), valid, 1'b0);
      check($sformatf("t2_rs1_%0d", k), read_rs1, 5'd5);
      tick();
    end
    haz_valid = '0;
    settle();
    check("t2_release", valid, 1'b1);
    pop_check("t2");
    tick();

    // 2b: rs2 hazard on writer 0
    offer(mk(5'd8, 5'd0, 5'd7, 32'd9), 1'b0, 6'd0, 1'b1);
    tick();
    idle_decode();
    haz_valid = 2'b01;
    haz_rd    = {5'd0, 5'd7};
    settle();
    check("t2b_blocked", valid, 1'b0);
    check("t2b_rs2", read_rs2, 5'd7);
    tick();
    haz_valid = '0;
    settle();
    check("t2b_release", valid, 1'b1);
    pop_check("t2b");
    tick();

    // 3: fill under stall, third entry refused, then pop+push while full
    stall = 1'b1;
    offer(mk(5'd10, 5'd1, 5'd2, 32'd10), 1'b0, 6'd0, 1'b1);
    settle();
    check("t3_a_dstall", decode_stall, 1'b0);
    tick();
    offer(mk(5'd11, 5'd2, 5'd3, 32'd11), 1'b0, 6'd0, 1'b1);
    settle();
    check("t3_b_dstall", decode_stall, 1'b0);
    check("t3_b_valid", valid, 1'b0);
    tick();
    offer(mk(5'd12, 5'd3, 5'd4, 32'd12), 1'b0, 6'd0, 1'b0);
    settle();
    check("t3_c_full", decode_stall, 1'b1);
    tick();
    stall = 1'b0;
    settle();
    check("t3_popush_dstall", decode_stall, 1'b0);
    check("t3_popush_valid", valid, 1'b1);
    pop_check("t3_a");
    offer(mk(5'd12, 5'd3, 5'd4, 32'd12), 1'b0, 6'd0, 1'b1);
    tick();
    stall = 1'b1;
    offer(mk(5'd13, 5'd4, 5'd5, 32'd13), 1'b0, 6'd0, 1'b0);
    settle();
    check("t3_still_full", decode_stall, 1'b1);
    tick();
    stall = 1'b0;
    idle_decode();
    settle();
    check("t3_b_issue", valid, 1'b1);
    pop_check("t3_b");
    tick();
    settle();
    check("t3_c_issue", valid, 1'b1);
    pop_check("t3_c");
    tick();
    settle();
    check("t3_drained", valid, 1'b0);

    // 4: x0 destination on a live writer is never a hazard
    offer(mk(5'd14, 5'd2, 5'd0, 32'd14), 1'b0, 6'd0, 1'b1);
    tick();
    idle_decode();
    haz_valid = 2'b01;
    haz_rd    = {5'd2, 5'd0};
    settle();
    check("t4_x0_valid", valid, 1'b1);
    pop_check("t4");
    tick();
    haz_valid = '0;

    // 5: exception entry ignores hazards
    offer(mk(5'd15, 5'd4, 5'd0, 32'd15), 1'b1, 6'd13, 1'b1);
    tick();
    idle_decode();
    haz_valid    = 2'b11;
    haz_rd       = {5'd4, 5'd4};
    haz_data_rdy = '0;
    settle();
    check("t5_exc_valid", valid, 1'b1);
    pop_check("t5");
    tick();
    haz_valid = '0;

    // 6: flush of a full buffer beats push and issue
    stall = 1'b1;
    offer(mk(5'd16, 5'd1, 5'd1, 32'd16), 1'b0, 6'd0, 1'b1);
    tick();
    offer(mk(5'd17, 5'd1, 5'd1, 32'd17), 1'b0, 6'd0, 1'b1);
    tick();
    offer(mk(5'd18, 5'd1, 5'd1, 32'd18), 1'b0, 6'd0, 1'b0);
    flush = 1'b1;
    settle();
    check("t6_flush_valid", valid, 1'b0);
    check("t6_flush_dstall", decode_stall, 1'b0);
    sb.delete();
    tick();
    flush = 1'b0;
    stall = 1'b0;
    idle_decode();
    settle();
    check("t6_empty", valid, 1'b0);
    offer(mk(5'd19, 5'd2, 5'd3, 32'd19), 1'b0, 6'd0, 1'b1);
    settle();
    check("t6_refill_dstall", decode_stall, 1'b0);
    tick();
    idle_decode();
    settle();
    check("t6_refill_valid", valid, 1'b1);
    pop_check("t6");
    tick();

    // 6b: asynchronous reset while stalled
    stall = 1'b1;
    offer(mk(5'd9, 5'd7, 5'd6, 32'd20), 1'b0, 6'd0, 1'b0);
    tick();
    idle_decode();
    settle();
    check("t6b_head_rs1", read_rs1, 5'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6b_async_rs1", read_rs1, '0);
    check("t6b_async_rs2", read_rs2, '0);
    check("t6b_async_instr", instr_out, '0);
    check("t6b_async_valid", valid, 1'b0);
    check("t6b_async_dstall", decode_stall, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    stall   = 1'b0;
    tick();
    offer(mk(5'd21, 5'd3, 5'd2, 32'd21), 1'b0, 6'd0, 1'b1);
    settle();
    check("t6b_first_push", decode_stall, 1'b0);
    tick();
    idle_decode();
    settle();
    check("t6b_valid", valid, 1'b1);
    pop_check("t6b");
    tick();
    settle();
    check("t6b_drained", valid, 1'b0);
    check("sb_leftover", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
